// File: rtl/l1d_way_hit_resolver.sv
// l1d_way_hit_resolver: per-channel registered way-hit classifier for the L1D
// tag-compare stage. Each channel is a single-entry valid/ready register that
// returns miss / single-hit / multi-hit plus the lowest hit way one cycle after
// accept. A sticky multi-hit flag and an optional saturating multi-hit event
// counter feed the cache error/CSR logic.
// Optional feature macro: L1D_MULTIHIT_COUNTER_EN (counter present when defined;
// otherwise multi_count_o is tied to zero with the same width).
module l1d_way_hit_resolver #(
    parameter int WAYS     = 4,
    parameter int CHANNELS = 2,
    parameter int CNT_W    = 8,
    localparam int WW      = $clog2(WAYS)
) (
    input  logic                     cpu_clk_i,
    input  logic                     cpu_rst_ni,
    input  logic [CHANNELS-1:0]      req_valid_i,
    output logic [CHANNELS-1:0]      req_ready_o,
    input  logic [CHANNELS*WAYS-1:0] req_hits_i,
    output logic [CHANNELS-1:0]      resp_valid_o,
    input  logic [CHANNELS-1:0]      resp_ready_i,
    output logic [CHANNELS-1:0]      resp_hit_o,
    output logic [CHANNELS-1:0]      resp_miss_o,
    output logic [CHANNELS-1:0]      resp_multi_o,
    output logic [CHANNELS*WW-1:0]   resp_way_o,
    input  logic                     clear_i,
    output logic                     multi_sticky_o,
    output logic [CNT_W-1:0]         multi_count_o
);

    // Event count must hold 0..CHANNELS; the counter sum gets at least one
    // extra bit on top of CNT_W so it can never wrap before saturating.
    localparam int EW = $clog2(CHANNELS + 1);
    localparam int SW = CNT_W + EW;

    // Index of the lowest set bit; scanning downward lets the lowest win.
    function automatic logic [WW-1:0] lowest_way(input logic [WAYS-1:0] h);
        logic [WW-1:0] w;
        w = {WW{1'b0}};
        for (int i = WAYS - 1; i >= 0; i--) begin
            w = h[i] ? WW'(i) : w;
        end
        return w;
    endfunction

    // Two or more bits set: clearing the lowest set bit leaves something.
    function automatic logic is_multi(input logic [WAYS-1:0] h);
        return |(h & (h - WAYS'(1)));
    endfunction

    logic [CHANNELS-1:0]    resp_valid_q, resp_valid_d;
    logic [CHANNELS-1:0]    resp_hit_q,   resp_hit_d;
    logic [CHANNELS-1:0]    resp_miss_q,  resp_miss_d;
    logic [CHANNELS-1:0]    resp_multi_q, resp_multi_d;
    logic [CHANNELS*WW-1:0] resp_way_q,   resp_way_d;
    logic                   sticky_q,     sticky_d;
    logic [CHANNELS-1:0]    accept_s;
    logic [EW-1:0]          event_cnt_s;

    // Ready depends only on the output register state and downstream ready.
    assign req_ready_o = ~resp_valid_q | resp_ready_i;

    // Per-channel next state: overwrite on accept, drop on pop, else hold.
    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_hit_d   = resp_hit_q;
        resp_miss_d  = resp_miss_q;
        resp_multi_d = resp_multi_q;
        resp_way_d   = resp_way_q;
        accept_s     = {CHANNELS{1'b0}};
        event_cnt_s  = {EW{1'b0}};
        for (int c = 0; c < CHANNELS; c++) begin
            accept_s[c] = req_valid_i[c] & req_ready_o[c];
            if (accept_s[c]) begin
                resp_valid_d[c]         = 1'b1;
                resp_miss_d[c]          = (req_hits_i[c*WAYS +: WAYS] == {WAYS{1'b0}});
                resp_multi_d[c]         = is_multi(req_hits_i[c*WAYS +: WAYS]);
                resp_hit_d[c]           = !resp_miss_d[c] && !resp_multi_d[c];
                resp_way_d[c*WW +: WW]  = lowest_way(req_hits_i[c*WAYS +: WAYS]);
                event_cnt_s             = event_cnt_s + EW'(resp_multi_d[c]);
            end else if (resp_valid_q[c] && resp_ready_i[c]) begin
                resp_valid_d[c] = 1'b0;
            end else begin
                resp_valid_d[c] = resp_valid_q[c];
            end
        end
    end

    // Sticky flag: a clear still keeps events accepted in the same cycle.
    always_comb begin
        if (clear_i) begin
            sticky_d = (event_cnt_s != {EW{1'b0}});
        end else begin
            sticky_d = sticky_q | (event_cnt_s != {EW{1'b0}});
        end
    end

    // Response and sticky registers with synchronous active-low reset.
    always_ff @(posedge cpu_clk_i) begin
        if (!cpu_rst_ni) begin
            resp_valid_q <= {CHANNELS{1'b0}};
            resp_hit_q   <= {CHANNELS{1'b0}};
            resp_miss_q  <= {CHANNELS{1'b0}};
            resp_multi_q <= {CHANNELS{1'b0}};
            resp_way_q   <= {(CHANNELS*WW){1'b0}};
            sticky_q     <= 1'b0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_hit_q   <= resp_hit_d;
            resp_miss_q  <= resp_miss_d;
            resp_multi_q <= resp_multi_d;
            resp_way_q   <= resp_way_d;
            sticky_q     <= sticky_d;
        end
    end

    assign resp_valid_o   = resp_valid_q;
    assign resp_hit_o     = resp_hit_q;
    assign resp_miss_o    = resp_miss_q;
    assign resp_multi_o   = resp_multi_q;
    assign resp_way_o     = resp_way_q;
    assign multi_sticky_o = sticky_q;

`ifdef L1D_MULTIHIT_COUNTER_EN
    logic [CNT_W-1:0] count_q, count_d;
    logic [SW-1:0]    sum_s;

    // Saturating counter: clear restarts from the same-cycle event count.
    always_comb begin
        if (clear_i) begin
            sum_s = SW'(event_cnt_s);
        end else begin
            sum_s = SW'(count_q) + SW'(event_cnt_s);
        end
        if (sum_s > SW'({CNT_W{1'b1}})) begin
            count_d = {CNT_W{1'b1}};
        end else begin
            count_d = sum_s[CNT_W-1:0];
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge cpu_clk_i) begin
        if (!cpu_rst_ni) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign multi_count_o = count_q;
`else
    assign multi_count_o = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_l1d_way_hit_resolver.sv
// Scoreboard bench for l1d_way_hit_resolver (WAYS=4, CHANNELS=2, CNT_W=2).
// The stimulus process pushes expected results computed from bit counts and a
// lowest-index search; a negedge monitor pops and compares them.
module tb_l1d_way_hit_resolver;

    localparam int WAYS  = 4;
    localparam int CH    = 2;
    localparam int CNT_W = 2;
    localparam int WW    = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic          hit;
        logic          miss;
        logic          multi;
        logic [WW-1:0] way;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  cpu_rst_ni = 1'b0;
    logic [CH-1:0]         req_valid_i = '0;
    logic [CH-1:0]         req_ready_o;
    logic [CH*WAYS-1:0]    req_hits_i = '0;
    logic [CH-1:0]         resp_valid_o;
    logic [CH-1:0]         resp_ready_i = '0;
    logic [CH-1:0]         resp_hit_o, resp_miss_o, resp_multi_o;
    logic [CH*WW-1:0]      resp_way_o;
    logic                  clear_i = 1'b0;
    logic                  multi_sticky_o;
    logic [CNT_W-1:0]      multi_count_o;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q [CH][$];
    int   sticky_m = 0;
    int   cnt_m    = 0;

    always #5 clk = ~clk;

    l1d_way_hit_resolver #(.WAYS(WAYS), .CHANNELS(CH), .CNT_W(CNT_W)) dut (
        .cpu_clk_i(clk), .cpu_rst_ni(cpu_rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_hits_i(req_hits_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_hit_o(resp_hit_o), .resp_miss_o(resp_miss_o), .resp_multi_o(resp_multi_o),
        .resp_way_o(resp_way_o), .clear_i(clear_i),
        .multi_sticky_o(multi_sticky_o), .multi_count_o(multi_count_o)
    );

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference: classify by population count, way = lowest set index.
    function automatic exp_t ref_result(input logic [WAYS-1:0] h);
        exp_t r;
        int   n;
        bit   found;
        n = $countones(h);
        r.miss  = (n == 0);
        r.hit   = (n == 1);
        r.multi = (n > 1);
        r.way   = '0;
        found   = 1'b0;
        for (int i = 0; i < WAYS; i++) begin
            if (h[i] && !found) begin
                r.way = WW'(i);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    // Drive one cycle of inputs, then update the model at the clock edge.
    task automatic step(input logic [CH-1:0] v, input logic [CH*WAYS-1:0] h,
                        input logic [CH-1:0] rr, input logic clr, input logic rst_n);
        bit [CH-1:0] acc;
        int e;
        req_valid_i  = v;
        req_hits_i   = h;
        resp_ready_i = rr;
        clear_i      = clr;
        cpu_rst_ni   = rst_n;
        for (int c = 0; c < CH; c++)
            acc[c] = v[c] && ((exp_q[c].size() == 0) || rr[c]);
        @(posedge clk);
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) exp_q[c].delete();
            sticky_m = 0;
            cnt_m    = 0;
        end else begin
            e = 0;
            for (int c = 0; c < CH; c++) begin
                if (acc[c]) begin
                    exp_t r;
                    r = ref_result(h[c*WAYS +: WAYS]);
                    exp_q[c].push_back(r);
                    if (r.multi) e++;
                end
            end
            sticky_m = clr ? int'(e > 0) : int'((sticky_m != 0) || (e > 0));
`ifdef L1D_MULTIHIT_COUNTER_EN
            cnt_m = clr ? sat(e) : sat(cnt_m + e);
`else
            cnt_m = 0;
`endif
        end
        #2;
    endtask

    // Directly after a reset edge every output register must read zero.
    task automatic check_reset_state();
        chk("rst_valid", int'(resp_valid_o), 0);
        chk("rst_hit",   int'(resp_hit_o),   0);
        chk("rst_miss",  int'(resp_miss_o),  0);
        chk("rst_multi", int'(resp_multi_o), 0);
        chk("rst_way",   int'(resp_way_o),   0);
        chk("rst_sticky", int'(multi_sticky_o), 0);
        chk("rst_count", int'(multi_count_o), 0);
        chk("rst_ready", int'(req_ready_o), 3);
    endtask

    // Monitor: compare the head of each channel queue, pop on handshake.
    always @(negedge clk) begin
        if (cpu_rst_ni === 1'b1) begin
            for (int c = 0; c < CH; c++) begin
                chk($sformatf("ready%0d", c), int'(req_ready_o[c]),
                    int'((exp_q[c].size() == 0) || resp_ready_i[c]));
                chk($sformatf("valid%0d", c), int'(resp_valid_o[c]), int'(exp_q[c].size() != 0));
                if (exp_q[c].size() != 0) begin
                    exp_t e;
                    e = exp_q[c][0];
                    chk($sformatf("hit%0d", c),   int'(resp_hit_o[c]),   int'(e.hit));
                    chk($sformatf("miss%0d", c),  int'(resp_miss_o[c]),  int'(e.miss));
                    chk($sformatf("multi%0d", c), int'(resp_multi_o[c]), int'(e.multi));
                    chk($sformatf("way%0d", c),   int'(resp_way_o[c*WW +: WW]), int'(e.way));
                    if (resp_ready_i[c]) void'(exp_q[c].pop_front());
                end
            end
            chk("sticky", int'(multi_sticky_o), sticky_m);
            chk("count",  int'(multi_count_o),  cnt_m);
        end
    end

    initial begin
        // Reset
        step(2'b00, 8'h00, 2'b00, 1'b0, 1'b0);
        step(2'b11, 8'hff, 2'b11, 1'b1, 1'b0);
        check_reset_state();
        // Single hit on ch0: way 2
        step(2'b01, {4'b0000, 4'b0100}, 2'b11, 1'b0, 1'b1);
        // Miss on ch0, multi-hit on ch1 (way 1)
        step(2'b11, {4'b1010, 4'b0000}, 2'b11, 1'b0, 1'b1);
        // Backpressure: ch1 stalled while ch0 streams
        step(2'b10, {4'b0001, 4'b0000}, 2'b01, 1'b0, 1'b1);
        step(2'b11, {4'b1000, 4'b0010}, 2'b01, 1'b0, 1'b1);
        step(2'b11, {4'b0100, 4'b1100}, 2'b01, 1'b0, 1'b1);
        step(2'b11, {4'b0010, 4'b0000}, 2'b01, 1'b0, 1'b1);
        // Release ch1 together with a new accept: replaced with no bubble
        step(2'b11, {4'b1000, 4'b0001}, 2'b11, 1'b0, 1'b1);
        step(2'b00, 8'h00, 2'b11, 1'b0, 1'b1);
        // Five multi-hit accepts saturate a 2-bit counter
        for (int i = 0; i < 5; i++) step(2'b01, {4'b0000, 4'b1111}, 2'b11, 1'b0, 1'b1);
        // Clear with two same-cycle multi-hits: count 2, sticky 1
        step(2'b11, {4'b0110, 4'b0011}, 2'b11, 1'b1, 1'b1);
        step(2'b00, 8'h00, 2'b11, 1'b0, 1'b1);
        // Plain clear
        step(2'b00, 8'h00, 2'b11, 1'b1, 1'b1);
        // Reset mid-operation with both channels stalled
        step(2'b11, {4'b1100, 4'b0101}, 2'b00, 1'b0, 1'b1);
        step(2'b11, {4'b1111, 4'b1111}, 2'b00, 1'b0, 1'b1);
        step(2'b11, {4'b1111, 4'b1111}, 2'b11, 1'b1, 1'b0);
        check_reset_state();
        step(2'b00, 8'h00, 2'b11, 1'b0, 1'b1);
        step(2'b00, 8'h00, 2'b11, 1'b0, 1'b1);
        // Randomized traffic with occasional clear and reset
        for (int i = 0; i < 600; i++) begin
            logic [CH-1:0]      v, rr;
            logic [CH*WAYS-1:0] h;
            logic               clr, rn;
            v   = CH'($urandom_range(0, 3));
            h   = (CH*WAYS)'($urandom);
            rr  = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
            clr = ($urandom_range(0, 9) == 0);
            rn  = ($urandom_range(0, 79) != 0);
            step(v, h, rr, clr, rn);
        end
        step(2'b00, 8'h00, 2'b11, 1'b0, 1'b1);
        step(2'b00, 8'h00, 2'b11, 1'b0, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
